// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - instruction field encoder feeding a program-memory write port through a 2-entry FIFO.
// Optional field checking is enabled by defining ENCODER_CHECK_EN.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [2:0]        rd,
    input  logic [2:0]        rs,
    input  logic [7:0]        imm,
    input  logic              last,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [15:0]       pm_wdata,
    input  logic              pm_ready,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    state_t      state;
    logic [15:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;
    logic [15:0] enc_word;
    logic        accept;
    logic        push;
    logic        pop;
    logic        wr_done;
    logic        hit_full;

    always_comb begin
        enc_word = {op, rd, rs, imm};
        case (op)
            2'b01:   enc_word = 16'h4000;
            2'b11:   enc_word = {2'b11, 6'b0, imm};
            default: enc_word = {op, rd, rs, imm};
        endcase
    end

    assign in_ready = (state == LOAD) && (occ != 2'd2) && !full;
    assign accept   = in_valid && in_ready;
    assign wr_done  = pm_we && pm_ready;
    // Filling the last address ends the session; nothing behind it may be written.
    assign hit_full = wr_done && (count == LAST_SLOT);
    assign pop      = (occ != 2'd0) && (!pm_we || pm_ready) && !hit_full;
    assign busy     = (state == LOAD) || (state == FLUSH);
    assign done     = (state == DONE);

`ifdef ENCODER_CHECK_EN
    logic bad_fields;
    assign bad_fields = ((op == 2'b01) && ((rd != 3'd0) || (rs != 3'd0) || (imm != 8'd0))) ||
                        ((op == 2'b11) && ((rd != 3'd0) || (rs != 3'd0)));
    assign push = accept && !bad_fields;
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            fifo_mem[0] <= 16'h0;
            fifo_mem[1] <= 16'h0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
            pm_we       <= 1'b0;
            pm_addr     <= '0;
            pm_wdata    <= 16'h0;
            count       <= '0;
            full        <= 1'b0;
`ifdef ENCODER_CHECK_EN
            err         <= 1'b0;
`endif
        end else begin
            if (wr_done) begin
                pm_addr <= pm_addr + 1'b1;
                count   <= count + 1'b1;
            end
            if (hit_full) begin
                full <= 1'b1;
            end

            if (pop) begin
                pm_we    <= 1'b1;
                pm_wdata <= fifo_mem[rd_ptr];
                rd_ptr   <= ~rd_ptr;
            end else if (wr_done) begin
                pm_we <= 1'b0;
            end

            if (push) begin
                fifo_mem[wr_ptr] <= enc_word;
                wr_ptr           <= ~wr_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};

`ifdef ENCODER_CHECK_EN
            if (accept && bad_fields) begin
                err <= 1'b1;
            end
`endif

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        pm_addr <= '0;
                        count   <= '0;
                        full    <= 1'b0;
`ifdef ENCODER_CHECK_EN
                        err     <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (hit_full) begin
                        state <= DONE;
                    end else if (accept && last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (hit_full || ((occ == 2'd0) && !pm_we)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (hit_full) begin
                occ    <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with a 4-word program memory.
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [2:0]    rd;
    logic [2:0]    rs;
    logic [7:0]    imm;
    logic          last;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [15:0]   pm_wdata;
    logic          pm_ready;
    logic          busy;
    logic          done;
    logic          full;
    logic [AW:0]   count;
    logic          err;

    int errors = 0;
    int checks = 0;

    logic [AW+15:0] exp_q[$];
    logic [AW+15:0] mon_e;
    logic [AW-1:0]  exp_addr;
    int             sess_pushed;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs(rs), .imm(imm), .last(last),
        .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .pm_ready(pm_ready),
        .busy(busy), .done(done), .full(full), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [1:0] o, input logic [2:0] d,
                                        input logic [2:0] s, input logic [7:0] i);
        case (o)
            2'b01:   return 16'h4000;
            2'b11:   return {2'b11, 6'd0, i};
            default: return {o, d, s, i};
        endcase
    endfunction

    function automatic bit is_bad(input logic [1:0] o, input logic [2:0] d,
                                  input logic [2:0] s, input logic [7:0] i);
`ifdef ENCODER_CHECK_EN
        return ((o == 2'b01) && (d != 0 || s != 0 || i != 0)) || ((o == 2'b11) && (d != 0 || s != 0));
`else
        return 1'b0;
`endif
    endfunction

    // A write completes on the next rising edge when pm_we and pm_ready are both high here.
    always @(negedge clk) begin
        if (n_reset && pm_we && pm_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%h, required no write", pm_addr, pm_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({pm_addr, pm_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL pm_write: addr=%0d data=%h, required addr=%0d data=%h",
                             pm_addr, pm_wdata, mon_e[AW+15:16], mon_e[15:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr = '0;
        sess_pushed = 0;
        checks++;
        if ({busy, done, count, err, full} !== {1'b1, 1'b0, {(AW+1){1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL start_state: busy=%b done=%b count=%0d err=%b full=%b, required 1 0 0 0 0",
                     busy, done, count, err, full);
        end
    endtask

    task automatic send_beat(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                             input logic [7:0] i, input logic l, input bit must, output bit acc);
        int n = 0;
        op = o; rd = d; rs = s; imm = i; last = l; in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        acc = in_ready;
        if (acc) begin
            if (!is_bad(o, d, s, i) && sess_pushed < DEPTH) begin
                exp_q.push_back({exp_addr, enc(o, d, s, i)});
                exp_addr++;
                sess_pushed++;
            end
        end else if (must) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: in_ready=0 after %0d cycles, required 1", n);
        end
        step();
        in_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL writes_pending: %0d expected writes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; start = 1'b0; in_valid = 1'b0; pm_ready = 1'b1;
        op = '0; rd = '0; rs = '0; imm = '0; last = 1'b0;
        #2;
        checks++;
        if ({pm_we, pm_addr, pm_wdata, count, busy, done, full, err, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%0d wdata=%h count=%0d busy=%b done=%b full=%b err=%b in_ready=%b, required all 0",
                     pm_we, pm_addr, pm_wdata, count, busy, done, full, err, in_ready);
        end
        step();
        step();
        n_reset = 1'b1;
        step();
        checks++;
        if ({busy, in_ready, pm_we} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b in_ready=%b pm_we=%b, required 0 0 0", busy, in_ready, pm_we);
        end
    endtask

    task automatic test_basic();
        bit acc;
        start_session();
        send_beat(2'b10, 3'd5, 3'd4, 8'h05, 1'b0, 1'b1, acc);
        send_beat(2'b11, 3'd0, 3'd0, 8'hF0, 1'b1, 1'b1, acc);
        wait_done();
        checks++;
        if ({done, busy, full, count, pm_addr} !== {1'b1, 1'b0, 1'b0, 3'd2, 2'd2}) begin
            errors++;
            $display("FAIL basic_status: done=%b busy=%b full=%b count=%0d addr=%0d, required 1 0 0 2 2",
                     done, busy, full, count, pm_addr);
        end
    endtask

    task automatic test_ignore_idle();
        op = 2'b00; rd = 3'd1; rs = 3'd1; imm = 8'h11; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ignore_idle: in_ready=%b in DONE, required 0", in_ready);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_nop();
        bit acc;
        start_session();
        send_beat(2'b01, 3'd5, 3'd0, 8'hFF, 1'b1, 1'b1, acc);
        wait_done();
        checks++;
        if ({err, count} !== {is_bad(2'b01, 3'd5, 3'd0, 8'hFF), 3'(sess_pushed)}) begin
            errors++;
            $display("FAIL nop_check: err=%b count=%0d, required err=%b count=%0d",
                     err, count, is_bad(2'b01, 3'd5, 3'd0, 8'hFF), sess_pushed);
        end
    endtask

    task automatic test_start_ignored();
        bit acc;
        start_session();
        send_beat(2'b00, 3'd1, 3'd1, 8'h01, 1'b0, 1'b1, acc);
        send_beat(2'b00, 3'd2, 3'd2, 8'h02, 1'b0, 1'b1, acc);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_load: busy=%b, required 1", busy);
        end
        send_beat(2'b00, 3'd3, 3'd3, 8'h03, 1'b1, 1'b1, acc);
        wait_done();
        checks++;
        if ({count, pm_addr} !== {3'd3, 2'd3}) begin
            errors++;
            $display("FAIL start_ignored_count: count=%0d addr=%0d, required 3 3", count, pm_addr);
        end
    endtask

    task automatic test_stall();
        bit acc;
        start_session();
        pm_ready = 1'b0;
        send_beat(2'b00, 3'd1, 3'd2, 8'h11, 1'b0, 1'b1, acc);
        send_beat(2'b10, 3'd3, 3'd4, 8'h22, 1'b0, 1'b1, acc);
        send_beat(2'b00, 3'd7, 3'd7, 8'hFF, 1'b0, 1'b1, acc);
        checks++;
        if ({in_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL stall_backpressure: in_ready=%b busy=%b, required 0 1", in_ready, busy);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({pm_we, pm_wdata} !== {1'b1, enc(2'b00, 3'd1, 3'd2, 8'h11)}) begin
                errors++;
                $display("FAIL stall_hold: we=%b wdata=%h, required 1 %h",
                         pm_we, pm_wdata, enc(2'b00, 3'd1, 3'd2, 8'h11));
            end
            step();
        end
        pm_ready = 1'b1;
        send_beat(2'b11, 3'd0, 3'd0, 8'h80, 1'b1, 1'b1, acc);
        wait_done();
        checks++;
        if ({count, full} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL stall_final: count=%0d full=%b, required 4 1", count, full);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        start_session();
        pm_ready = 1'b0;
        send_beat(2'b00, 3'd1, 3'd0, 8'hA1, 1'b0, 1'b1, acc);
        send_beat(2'b00, 3'd2, 3'd0, 8'hA2, 1'b0, 1'b1, acc);
        send_beat(2'b00, 3'd3, 3'd0, 8'hA3, 1'b0, 1'b1, acc);
        n_reset = 1'b0;
        #1;
        checks++;
        if ({pm_we, count, busy, in_ready, pm_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid: we=%b count=%0d busy=%b in_ready=%b wdata=%h, required all 0",
                     pm_we, count, busy, in_ready, pm_wdata);
        end
        exp_q.delete();
        step();
        step();
        n_reset = 1'b1;
        pm_ready = 1'b1;
        repeat (6) step();
        checks++;
        if ({pm_we, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_after: we=%b busy=%b done=%b, required 0 0 0", pm_we, busy, done);
        end
    endtask

    task automatic test_full();
        bit acc;
        start_session();
        pm_ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            send_beat(2'b10, 3'(b), 3'(b + 1), 8'(8'h40 + b), 1'b0, 1'b0, acc);
        end
        wait_done();
        checks++;
        if ({full, done, in_ready, count, pm_addr} !== {1'b1, 1'b1, 1'b0, 3'd4, 2'd0}) begin
            errors++;
            $display("FAIL full_status: full=%b done=%b in_ready=%b count=%0d addr=%0d, required 1 1 0 4 0",
                     full, done, in_ready, count, pm_addr);
        end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_idle();
        test_nop();
        test_start_ignored();
        test_stall();
        test_reset_mid();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
